instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream stage of Program_Memory: owns the program counter and drives it as the memory read address.
//  It captures the returned 16-bit word into an instruction register (the IF/ID register) for the decoder.
//  It resolves jumps and HALT locally and accepts taken-fork redirects from execute.
//  It supports a downstream stall and a halt/resume handshake.
// PARAMETERS
//  N           10       PC / program-memory address width
//  RESET_PC    0        PC value loaded on reset (N bits)
//  OP_JUMP     4'b1010  opcode: absolute jump, target = instr[N-1:0]
//  OP_HALT     4'b1110  opcode: halt fetch
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous reset, active-high
//  stall           in   1   hold PC and instruction register this cycle
//  redirect_valid  in   1   execute resolved a taken fork; load redirect_pc
//  redirect_pc     in   N   fork target (execute computes PC+1+offset)
//  resume          in   1   leave HALTED; continue at halt address + 1
//  instr_in        in   16  program-memory read data (combinational from pc_out)
//  pc_out          out  N   current PC; drives the program-memory address
//  ir_out          out  16  instruction register
//  ir_pc           out  N   address ir_out was fetched from
//  ir_valid        out  1   ir_out holds a live instruction
//  halted          out  1   fetch stopped on HALT
//  fetch_count     out  16  count of instructions issued (ir_valid loads)
// BEHAVIOUR
//  Reset values (rst=1 at posedge):
//   - pc_out=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0.
//   - State becomes RUN.
//  Memory timing: instr_in is valid in the same cycle as pc_out. Fetch latency is 1 clk (word appears on ir_out next edge).
//  States: RUN, HALTED. Per-edge priority: rst > redirect_valid > stall > normal.
//  redirect_valid (any state, stall ignored):
//   - pc <= redirect_pc; ir_valid <= 0 (flush wrong-path word); ir_out and ir_pc hold.
//   - State <= RUN; halted <= 0. A speculatively fetched HALT is cancelled this way.
//  stall=1 (no redirect): pc, ir_out, ir_pc, ir_valid, fetch_count and state all hold.
//  RUN, no stall/redirect:
//   - ir_out <= instr_in; ir_pc <= pc; ir_valid <= 1; fetch_count <= fetch_count+1 (wraps at 2^16).
//   - instr_in[15:12]==OP_JUMP: pc <= instr_in[N-1:0]. The jump word still passes to ir_out as a no-op for the decoder.
//   - instr_in[15:12]==OP_HALT: pc holds; state <= HALTED; halted <= 1 on the same edge. The HALT word is issued with ir_valid=1.
//   - Otherwise: pc <= pc+1, modulo 2^N (2^N-1 wraps to 0).
//  HALTED, no redirect:
//   - ir_valid <= 0; pc, ir_out and fetch_count hold; halted stays 1.
//   - resume=1: pc <= pc+1; state <= RUN; halted <= 0. First new word is captured on the following edge.
//   - resume is ignored in RUN. stall has no additional effect in HALTED.
//  Fork opcodes (0000-0011, 1000-1001) are not decoded here. Fetch continues sequentially until redirect_valid.
//  Invariant: halted==1 iff state==HALTED.
//  Reset mid-operation: all state is reinitialised regardless of stall, redirect or halt.
// TESTING
//  1 Hold rst 2 clk, release -> pc_out=0, ir_valid=0. Next edge: ir_out=mem[0], ir_pc=0, pc_out=1, fetch_count=1.
//  2 Fetch 16'b1010000000010101 at pc=23 -> next edge: pc_out=21, ir_out=that word, ir_valid=1.
//  3 Fetch 16'b1110000000000000 at pc=24 -> halted=1, pc_out=24.
//    Next edge ir_valid=0, count frozen. Pulse resume -> pc_out=25, halted=0.
//  4 Fork flush: redirect_valid=1, redirect_pc=11 at pc=10 -> pc_out=11, ir_valid=0.
//    Same while HALTED at 24 -> halted=0, pc_out=11.
//  5 stall=1 for 3 clk at pc=5 -> pc_out, ir_out, fetch_count unchanged.
//    stall+redirect_valid (pc 30) -> pc_out=30.
//  6 Wrap: pc=1023, non-jump word -> pc_out=0. rst and redirect_valid on the same edge -> pc_out=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, IF/ID register, jump/halt resolution and redirect handling
module instruction_fetch_unit #(
    parameter int           N        = 10,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [3:0]   OP_JUMP  = 4'b1010,
    parameter logic [3:0]   OP_HALT  = 4'b1110
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    input  logic         resume,
    input  logic [15:0]  instr_in,
    output logic [N-1:0] pc_out,
    output logic [15:0]  ir_out,
    output logic [N-1:0] ir_pc,
    output logic         ir_valid,
    output logic         halted,
    output logic [15:0]  fetch_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [N-1:0] PC_ONE = 1;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [15:0]  ir_q, ir_d;
    logic [N-1:0] ir_pc_q, ir_pc_d;
    logic         ir_valid_q, ir_valid_d;
    logic [15:0]  count_q, count_d;
    logic [3:0]   opcode;

    assign opcode = instr_in[15:12];

    // Next-state logic: redirect beats everything, then per-state fetch/halt rules.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;

        if (redirect_valid) begin
            // Taken fork: flush the wrong-path word, keep the last issued one visible.
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        ir_d       = instr_in;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        count_d    = count_q + 16'd1;
                        if (opcode == OP_JUMP) begin
                            // Jump resolved here; the word still flows on as a decoder no-op.
                            pc_d = instr_in[N-1:0];
                        end else if (opcode == OP_HALT) begin
                            // PC parks on the HALT address so resume can step past it.
                            state_d = ST_HALTED;
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                end
                ST_HALTED: begin
                    // Stall is irrelevant here: nothing is being fetched anyway.
                    ir_valid_d = 1'b0;
                    if (resume) begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ir_q       <= 16'd0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            count_q    <= count_d;
        end
    end

    assign pc_out      = pc_q;
    assign ir_out      = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = count_q;

endmodule
